// File: rtl/telemetry_framer_if.sv
// Frame-input handshake plus uart_tx byte interface shared by telemetry_framer and its environment.
interface telemetry_framer_if #(
  parameter int NUM_CH   = 2,
  parameter int CH_WIDTH = 16
);
  logic                       frame_valid;
  logic                       frame_ready;
  logic [NUM_CH*CH_WIDTH-1:0] ch_data;
  logic [7:0]                 tx_data;
  logic                       tx_start;
  logic                       tx_busy;
  logic                       tx_done;

  // master: estimator + uart_tx side feeding the framer; slave: the framer itself
  modport master (
    output frame_valid, ch_data, tx_busy, tx_done,
    input  frame_ready, tx_data, tx_start
  );
  modport slave (
    input  frame_valid, ch_data, tx_busy, tx_done,
    output frame_ready, tx_data, tx_start
  );
endinterface

// File: rtl/telemetry_framer.sv
// Multi-channel telemetry packetiser: header, sequence byte, big-endian sign-extended channels.
// Define TLM_CHECKSUM_EN to append an 8-bit sum of the sequence and payload bytes.
module telemetry_framer #(
  parameter int          NUM_CH    = 2,
  parameter int          CH_WIDTH  = 16,
  parameter int          HDR_BYTES = 2,
  parameter logic [31:0] HEADER    = 32'h0000DEAD
) (
  input  logic              clk,
  input  logic              rst,
  telemetry_framer_if.slave bus,
  output logic [7:0]        seq_num,
  output logic [7:0]        drop_count,
  output logic              frame_sent
);
  localparam int BPC       = (CH_WIDTH + 7) / 8;
  localparam int EXT_W     = BPC * 8;
  localparam int PAY_BYTES = NUM_CH * BPC;
`ifdef TLM_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif
  localparam int FRAME_LEN = HDR_BYTES + 1 + PAY_BYTES + CSUM_BYTES;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t                     state_reg;
  logic [NUM_CH*CH_WIDTH-1:0] snap_reg;
  logic [IDX_W-1:0]           idx_reg;
  logic                       frame_ready_reg;
  logic                       tx_start_reg;
  logic                       frame_sent_reg;
  logic [7:0]                 tx_data_reg;
  logic [7:0]                 seq_reg;
  logic [7:0]                 drop_reg;

  // ch0 occupies the top of the payload so payload byte 0 is the first one sent
  logic [PAY_BYTES*8-1:0]     payload;
  logic [7:0]                 frame_bytes [FRAME_LEN];

  for (genvar gi = 0; gi < HDR_BYTES; gi++) begin : g_hdr
    assign frame_bytes[gi] = HEADER[(HDR_BYTES-1-gi)*8 +: 8];
  end

  assign frame_bytes[HDR_BYTES] = seq_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [EXT_W-1:0] ext;
    assign ext = EXT_W'($signed(snap_reg[gi*CH_WIDTH +: CH_WIDTH]));
    assign payload[(NUM_CH-1-gi)*EXT_W +: EXT_W] = ext;
  end

  for (genvar gi = 0; gi < PAY_BYTES; gi++) begin : g_pay
    assign frame_bytes[HDR_BYTES+1+gi] = payload[(PAY_BYTES-1-gi)*8 +: 8];
  end

`ifdef TLM_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = seq_reg;
    for (int i = 0; i < PAY_BYTES; i++) begin
      csum = csum + payload[i*8 +: 8];
    end
  end
  assign frame_bytes[FRAME_LEN-1] = csum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      snap_reg        <= '0;
      idx_reg         <= '0;
      frame_ready_reg <= 1'b1;
      tx_start_reg    <= 1'b0;
      frame_sent_reg  <= 1'b0;
      tx_data_reg     <= 8'h00;
      seq_reg         <= 8'h00;
      drop_reg        <= 8'h00;
    end else begin
      tx_start_reg   <= 1'b0;
      frame_sent_reg <= 1'b0;
      if (bus.frame_valid && !frame_ready_reg && drop_reg != 8'hFF) begin
        drop_reg <= drop_reg + 8'd1;
      end
      case (state_reg)
        IDLE: begin
          // ready is re-raised one cycle after the frame_sent edge
          if (frame_ready_reg && bus.frame_valid) begin
            snap_reg        <= bus.ch_data;
            idx_reg         <= '0;
            frame_ready_reg <= 1'b0;
            state_reg       <= SEND;
          end else begin
            frame_ready_reg <= 1'b1;
          end
        end
        SEND: begin
          if (!bus.tx_busy) begin
            tx_data_reg  <= frame_bytes[idx_reg];
            tx_start_reg <= 1'b1;
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.tx_done) begin
            if (idx_reg == LAST_IDX) begin
              frame_sent_reg <= 1'b1;
              seq_reg        <= seq_reg + 8'd1;
              state_reg      <= IDLE;
            end else begin
              idx_reg   <= idx_reg + IDX_W'(1);
              state_reg <= SEND;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.frame_ready = frame_ready_reg;
  assign bus.tx_start    = tx_start_reg;
  assign bus.tx_data     = tx_data_reg;
  assign seq_num         = seq_reg;
  assign drop_count      = drop_reg;
  assign frame_sent      = frame_sent_reg;
endmodule
